dcache_resp: RTL and testbench

- Data-side memory responder: the slave end of the core's dcache_* request/valid interface.
- Backs the core in simulation and simple FPGA builds with a word-organised RAM, a programmable response latency, and byte/half/word access with optional sign extension.
- Sits between core and nothing else; one outstanding request at a time.

---
 rtl/dcache_resp_pkg.sv | 29 ++
 rtl/dcache_resp_lane.sv | 52 +++++
 rtl/dcache_resp.sv | 179 +++++++++++++++++
 tb/tb_dcache_resp.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_resp_pkg.sv
// dcache_resp_pkg: shared definitions for the dcache_resp memory responder.
//   - access width encodings driven on dcache_width
//   - responder state enum
//   - seed, taps and step function for the optional random-latency LFSR
//     (used only when DCACHE_RESP_RAND_LAT_EN is defined)
package dcache_resp_pkg;

    localparam logic [1:0] WIDTH_B = 2'b00;
    localparam logic [1:0] WIDTH_H = 2'b01;
    localparam logic [1:0] WIDTH_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1:
    // the feedback is the XOR of bits 0, 2, 3 and 5.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        logic fb;
        fb = ^(cur & LFSR_TAPS);
        return {fb, cur[15:1]};
    endfunction

endpackage

// File: rtl/dcache_resp_lane.sv
// dcache_resp_lane: combinational byte-lane unit.
//   word   - current RAM word at the accessed index
//   lane   - byte address bits [1:0]
//   width  - access width (byte/half/word, 11 illegal)
//   ext    - 1 = sign-extend narrow reads, 0 = zero-extend
//   wdata  - right-aligned write data
//   rdata  - right-aligned, extended read result (0 for illegal width)
//   wmerge - word with only the addressed byte lanes replaced by wdata
module dcache_resp_lane
    import dcache_resp_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [1:0]  width,
    input  logic        ext,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [31:0] wmerge
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane extract with extension, and byte-enable write merge
    always_comb begin
        byte_s = word[{lane, 3'b000} +: 8];
        half_s = word[{lane[1], 4'b0000} +: 16];
        rdata  = 32'h0000_0000;
        wmerge = word;
        case (width)
            WIDTH_B: begin
                rdata = {{24{ext & byte_s[7]}}, byte_s};
                wmerge[{lane, 3'b000} +: 8] = wdata[7:0];
            end
            WIDTH_H: begin
                // addr[0] is ignored: a misaligned half is aligned down
                rdata = {{16{ext & half_s[15]}}, half_s};
                wmerge[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            end
            WIDTH_W: begin
                rdata  = word;
                wmerge = wdata;
            end
            default: begin
                // illegal width: read returns 0, write leaves the word intact
                rdata  = 32'h0000_0000;
                wmerge = word;
            end
        endcase
    end

endmodule

// File: rtl/dcache_resp.sv
// dcache_resp: data-side memory responder (slave end of the dcache_* interface).
// Word-organised RAM with a programmable response latency and byte/half/word
// access with optional sign extension. One request outstanding at a time.
// Ports:
//   clk, rst           - rising-edge clock, asynchronous active-high reset
//   dcache_r_ena/w_ena - read/write request, held until dcache_valid (both = write)
//   dcache_ext         - sign-extend narrow reads
//   dcache_width       - 00 byte, 01 half, 10 word, 11 illegal
//   dcache_addr        - byte address (upper bits beyond the RAM wrap)
//   dcache_data_in     - right-aligned write data
//   dcache_valid       - one-cycle completion pulse, LATENCY cycles after acceptance
//   dcache_data_out    - read result during dcache_valid (0 for writes)
// Build option: define DCACHE_RESP_RAND_LAT_EN to draw each request's latency
// from a 16-bit LFSR as 1 + (lfsr[3:0] mod LATENCY).
module dcache_resp
    import dcache_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dcache_r_ena,
    input  logic        dcache_w_ena,
    input  logic        dcache_ext,
    input  logic [1:0]  dcache_width,
    input  logic [31:0] dcache_addr,
    input  logic [31:0] dcache_data_in,
    output logic        dcache_valid,
    output logic [31:0] dcache_data_out
);

    localparam int         IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT_4 = 4'(LATENCY);

    state_t           state_r;
    logic [3:0]       cnt_r;
    logic [IDX_W-1:0] idx_r;
    logic [1:0]       lane_r;
    logic [1:0]       width_r;
    logic             ext_r;
    logic             wr_r;
    logic [31:0]      wdata_r;
    logic [31:0]      mem_r [DEPTH_WORDS];

    logic             req_s;
    logic [3:0]       load_s;
    logic [IDX_W-1:0] sel_idx_s;
    logic [1:0]       sel_lane_s;
    logic [1:0]       sel_width_s;
    logic             sel_ext_s;
    logic             sel_wr_s;
    logic [31:0]      word_s;
    logic [31:0]      rdata_s;
    logic [31:0]      wmerge_s;
    logic [31:0]      resp_data_s;
    logic             unused_s;

    assign req_s    = dcache_r_ena | dcache_w_ena;
    // address bits above the RAM index are deliberately ignored (wrap)
    assign unused_s = ^dcache_addr[31:IDX_W+2];

`ifdef DCACHE_RESP_RAND_LAT_EN
    logic [15:0] lfsr_r;

    // Latency LFSR: steps once per accepted request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_r <= LFSR_SEED;
        end else if (state_r == IDLE && req_s) begin
            lfsr_r <= lfsr_next(lfsr_r);
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

    // counter load = effective latency - 1, drawn from the pre-step value
    assign load_s = lfsr_r[3:0] % LAT_4;
`else
    assign load_s = LAT_4 - 4'd1;
`endif

    // In IDLE look at the live request so a zero-count accept can read at once
    always_comb begin
        if (state_r == IDLE) begin
            sel_idx_s   = dcache_addr[IDX_W+1:2];
            sel_lane_s  = dcache_addr[1:0];
            sel_width_s = dcache_width;
            sel_ext_s   = dcache_ext;
            sel_wr_s    = dcache_w_ena;
        end else begin
            sel_idx_s   = idx_r;
            sel_lane_s  = lane_r;
            sel_width_s = width_r;
            sel_ext_s   = ext_r;
            sel_wr_s    = wr_r;
        end
    end

    assign word_s      = mem_r[sel_idx_s];
    assign resp_data_s = sel_wr_s ? 32'h0000_0000 : rdata_s;

    dcache_resp_lane u_lane (
        .word   (word_s),
        .lane   (sel_lane_s),
        .width  (sel_width_s),
        .ext    (sel_ext_s),
        .wdata  (wdata_r),
        .rdata  (rdata_s),
        .wmerge (wmerge_s)
    );

    // Request FSM, latency counter and registered response outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r         <= IDLE;
            cnt_r           <= 4'd0;
            idx_r           <= '0;
            lane_r          <= 2'b00;
            width_r         <= 2'b00;
            ext_r           <= 1'b0;
            wr_r            <= 1'b0;
            wdata_r         <= 32'h0000_0000;
            dcache_valid    <= 1'b0;
            dcache_data_out <= 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    dcache_valid    <= 1'b0;
                    dcache_data_out <= 32'h0000_0000;
                    if (req_s) begin
                        idx_r   <= sel_idx_s;
                        lane_r  <= sel_lane_s;
                        width_r <= sel_width_s;
                        ext_r   <= sel_ext_s;
                        wr_r    <= sel_wr_s;
                        wdata_r <= dcache_data_in;
                        cnt_r   <= load_s;
                        if (load_s == 4'd0) begin
                            state_r         <= RESP;
                            dcache_valid    <= 1'b1;
                            dcache_data_out <= resp_data_s;
                        end else begin
                            state_r <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    cnt_r <= cnt_r - 4'd1;
                    // count reaches 0 on this edge: respond in the next cycle
                    if (cnt_r == 4'd1) begin
                        state_r         <= RESP;
                        dcache_valid    <= 1'b1;
                        dcache_data_out <= resp_data_s;
                    end
                end
                RESP: begin
                    // enables seen here are ignored; they re-request from IDLE
                    state_r         <= IDLE;
                    dcache_valid    <= 1'b0;
                    dcache_data_out <= 32'h0000_0000;
                end
                default: begin
                    state_r         <= IDLE;
                    dcache_valid    <= 1'b0;
                    dcache_data_out <= 32'h0000_0000;
                end
            endcase
        end
    end

    // RAM write port: a write commits on the edge leaving RESP, never under reset
    always_ff @(posedge clk) begin
        if (!rst && state_r == RESP && wr_r && width_r != 2'b11) begin
            mem_r[idx_r] <= wmerge_s;
        end
    end

endmodule

// File: tb/tb_dcache_resp.sv
`timescale 1ns/1ps
module tb_dcache_resp;

    localparam int DEPTH_WORDS = 1024;
    localparam int LATENCY     = 2;
    localparam int TIMEOUT     = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic        dcache_r_ena;
    logic        dcache_w_ena;
    logic        dcache_ext;
    logic [1:0]  dcache_width;
    logic [31:0] dcache_addr;
    logic [31:0] dcache_data_in;
    logic        dcache_valid;
    logic [31:0] dcache_data_out;

    always #5 clk = ~clk;

    dcache_resp #(.DEPTH_WORDS(DEPTH_WORDS), .LATENCY(LATENCY)) dut (
        .clk             (clk),
        .rst             (rst),
        .dcache_r_ena    (dcache_r_ena),
        .dcache_w_ena    (dcache_w_ena),
        .dcache_ext      (dcache_ext),
        .dcache_width    (dcache_width),
        .dcache_addr     (dcache_addr),
        .dcache_data_in  (dcache_data_in),
        .dcache_valid    (dcache_valid),
        .dcache_data_out (dcache_data_out)
    );

    int          checks = 0;
    int          errors = 0;
    int          issued = 0;
    int          seen   = 0;
    logic [31:0] exp_q [$];
    logic [31:0] model_mem [DEPTH_WORDS];
    logic [15:0] m_lfsr;
    logic [31:0] rnd_addr;
    logic [31:0] rnd_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int word_idx(input logic [31:0] a);
        return int'((a >> 2) % DEPTH_WORDS);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, input logic [1:0] w,
                                               input logic ext);
        logic [31:0] word;
        logic [31:0] v;
        word = model_mem[word_idx(a)];
        case (w)
            2'b00: begin
                v = (word >> (8 * (a % 4))) & 32'h0000_00FF;
                if (ext && v >= 32'h80) v = v | 32'hFFFF_FF00;
            end
            2'b01: begin
                v = (word >> (16 * ((a / 2) % 2))) & 32'h0000_FFFF;
                if (ext && v >= 32'h8000) v = v | 32'hFFFF_0000;
            end
            2'b10:   v = word;
            default: v = 32'h0;
        endcase
        return v;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [1:0] w, input logic [31:0] d);
        logic [31:0] mask;
        int          sh;
        case (w)
            2'b00:   begin sh = 8 * int'(a % 4);        mask = 32'h0000_00FF << sh; end
            2'b01:   begin sh = 16 * int'((a / 2) % 2); mask = 32'h0000_FFFF << sh; end
            2'b10:   begin sh = 0;                      mask = 32'hFFFF_FFFF;       end
            default: begin sh = 0;                      mask = 32'h0;               end
        endcase
        model_mem[word_idx(a)] = (model_mem[word_idx(a)] & ~mask) | ((d << sh) & mask);
    endtask

    // Latency the bench expects for the next accepted request
    function automatic int next_latency();
`ifdef DCACHE_RESP_RAND_LAT_EN
        int   lat;
        logic fb;
        lat    = 1 + int'(m_lfsr[3:0]) % LATENCY;
        fb     = m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5];
        m_lfsr = {fb, m_lfsr[15:1]};
        return lat;
`else
        return LATENCY;
`endif
    endfunction

    // Issue one request, record its expected response, check its latency
    task automatic issue(input logic rd, input logic wr, input logic [1:0] w, input logic ext,
                         input logic [31:0] a, input logic [31:0] d, input bit hold);
        int lat;
        int n;
        lat = next_latency();
        @(posedge clk);
        #1;
        dcache_r_ena   = rd;
        dcache_w_ena   = wr;
        dcache_width   = w;
        dcache_ext     = ext;
        dcache_addr    = a;
        dcache_data_in = d;
        if (wr) begin
            model_write(a, w, d);
            exp_q.push_back(32'h0);
        end else begin
            exp_q.push_back(model_read(a, w, ext));
        end
        issued++;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!dcache_valid && n < TIMEOUT);
        // first negedge precedes the accepting edge
        check("latency", 32'(n - 1), 32'(lat));
        if (!dcache_valid) exp_q.delete();
        if (!hold) begin
            dcache_r_ena = 1'b0;
            dcache_w_ena = 1'b0;
        end
    endtask

    // Monitor: pop and compare on every response pulse
    always @(negedge clk) begin
        if (dcache_valid) begin
            seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                check("data_out", dcache_data_out, exp_q.pop_front());
            end
        end
    end

    initial begin
        rst            = 1'b1;
        dcache_r_ena   = 1'b0;
        dcache_w_ena   = 1'b0;
        dcache_ext     = 1'b0;
        dcache_width   = 2'b00;
        dcache_addr    = 32'h0;
        dcache_data_in = 32'h0;
        m_lfsr         = 16'hACE1;
        repeat (3) @(negedge clk);
        check("reset_valid", 32'(dcache_valid), 32'd0);
        check("reset_data", dcache_data_out, 32'h0);
        rst = 1'b0;

        // give the words used below known contents
        for (int i = 0; i < 32; i++) issue(1'b0, 1'b1, 2'b10, 1'b0, 32'(i * 4), $urandom(), 1'b0);

        // word write/read, byte merge, signed/unsigned byte reads
        issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0);
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
        issue(1'b0, 1'b1, 2'b00, 1'b0, 32'h12, 32'h0000_0080, 1'b0);
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
        issue(1'b1, 1'b0, 2'b00, 1'b1, 32'h12, 32'h0, 1'b0);
        issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h12, 32'h0, 1'b0);
        // half lane, misaligned signed read, low half preserved
        issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_8001, 1'b0);
        issue(1'b1, 1'b0, 2'b01, 1'b1, 32'h23, 32'h0, 1'b0);
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0);
        // address wrap, illegal width write and read
        issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h1004, 32'h1111_1111, 1'b0);
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0004, 32'h0, 1'b0);
        issue(1'b0, 1'b1, 2'b11, 1'b0, 32'h0004, 32'hFFFF_FFFF, 1'b0);
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0004, 32'h0, 1'b0);
        issue(1'b1, 1'b0, 2'b11, 1'b1, 32'h0004, 32'h0, 1'b0);
        // both enables high acts as a write
        issue(1'b1, 1'b1, 2'b00, 1'b1, 32'h09, 32'h0000_00A5, 1'b0);
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 1'b0);

        // reset while a write of 0x55 to 0x40 is in flight
        @(posedge clk);
        #1;
        dcache_w_ena   = 1'b1;
        dcache_r_ena   = 1'b0;
        dcache_width   = 2'b10;
        dcache_addr    = 32'h40;
        dcache_data_in = 32'h55;
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_mid_valid", 32'(dcache_valid), 32'd0);
        end
        dcache_w_ena = 1'b0;
        rst          = 1'b0;
        m_lfsr       = 16'hACE1;
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b0);

        // back-to-back with enables held through RESP
        for (int i = 0; i < 8; i++) begin
            rnd_addr = 32'($urandom_range(0, 31)) << 2;
            issue(1'b1, (i % 2) == 1, 2'b10, 1'b0, rnd_addr, $urandom(), i != 7);
        end

        // randomized traffic
        for (int i = 0; i < 150; i++) begin
            int op;
            op       = int'($urandom_range(0, 2));
            rnd_addr = ($urandom() & 32'hFFFF_F000) | (32'($urandom_range(0, 31)) << 2)
                       | 32'($urandom_range(0, 3));
            rnd_data = $urandom();
            issue(op != 1, op != 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  rnd_addr, rnd_data, $urandom_range(0, 1) == 1);
        end
        dcache_r_ena = 1'b0;
        dcache_w_ena = 1'b0;

        repeat (6) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("valid_count", 32'(seen), 32'(issued));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
